// File: rtl/bp_btb.sv
// Branch target buffer: MRU-ordered {pc, npc} table fed by the pre-decoder and
// the execute stage, answering one registered lookup per cycle.

module bp_btb_cmp #(
   parameter int W = 39
) (
   input  logic [W-1:0] entry_pc,
   input  logic         entry_valid,
   input  logic [W-1:0] pc,
   output logic         match
);
   assign match = entry_valid && (entry_pc == pc);
endmodule

module bp_btb #(
   parameter int CFG_BTB_SIZE      = 8,
   parameter int CFG_CPU_ADDR_BITS = 39
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_flush_pipeline,
   input  logic                         i_we,
   input  logic                         i_we_exec,
   input  logic [CFG_CPU_ADDR_BITS-1:0] i_we_pc,
   input  logic [CFG_CPU_ADDR_BITS-1:0] i_we_npc,
   input  logic                         i_bp_req,
   input  logic [CFG_CPU_ADDR_BITS-1:0] i_bp_pc,
   output logic                         o_bp_valid,
   output logic                         o_bp_hit,
   output logic                         o_bp_exec,
   output logic [CFG_CPU_ADDR_BITS-1:0] o_bp_npc
);
   localparam int W      = CFG_CPU_ADDR_BITS;
   localparam int SIZE   = CFG_BTB_SIZE;
   localparam int STAGES = 1;

   typedef struct packed {
      logic [W-1:0] pc;
      logic [W-1:0] npc;
      logic         exec;
      logic         valid;
   } btb_entry_t;

   btb_entry_t        tbl   [SIZE];
   btb_entry_t        tbl_n [SIZE];
   btb_entry_t        new_ent;
   logic [SIZE-1:0]   we_match;
   logic [SIZE-1:0]   rd_match;
   logic              we_blocked;
   logic              seen;
   logic              rd_hit;
   logic              rd_exec;
   logic [W-1:0]      rd_npc;
   logic [STAGES:0]   vld_pipe;

   for (genvar g = 0; g < SIZE; g++) begin : g_ent
      bp_btb_cmp #(.W(W)) u_we_cmp (
         .entry_pc   (tbl[g].pc),
         .entry_valid(tbl[g].valid),
         .pc         (i_we_pc),
         .match      (we_match[g])
      );
      bp_btb_cmp #(.W(W)) u_rd_cmp (
         .entry_pc   (tbl[g].pc),
         .entry_valid(tbl[g].valid),
         .pc         (i_bp_pc),
         .match      (rd_match[g])
      );
   end

   // Entries above the matching slot (or all of them on a miss) slide down one
   // place; the write always lands at index 0.
   always_comb begin
      new_ent    = '{pc: i_we_pc, npc: i_we_npc, exec: i_we_exec, valid: 1'b1};
      we_blocked = 1'b0;
      seen       = 1'b0;
      for (int i = 0; i < SIZE; i++) begin
         tbl_n[i] = tbl[i];
         if (we_match[i] && tbl[i].exec && !i_we_exec) we_blocked = 1'b1;
      end
      tbl_n[0] = new_ent;
      for (int i = 1; i < SIZE; i++) begin
         seen     = seen | we_match[i-1];
         tbl_n[i] = seen ? tbl[i] : tbl[i-1];
      end
   end

   // Writes keep pcs unique, so at most one lookup match can be OR-ed in.
   always_comb begin
      rd_hit  = |rd_match;
      rd_exec = 1'b0;
      rd_npc  = '0;
      for (int i = 0; i < SIZE; i++) begin
         if (rd_match[i]) begin
            rd_exec = rd_exec | tbl[i].exec;
            rd_npc  = rd_npc | tbl[i].npc;
         end
      end
      if (!rd_hit) rd_npc = i_bp_pc + W'(4);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < SIZE; i++) tbl[i] <= '0;
      end else if (i_flush_pipeline) begin
         for (int i = 0; i < SIZE; i++) tbl[i].valid <= 1'b0;
      end else if (i_we && !we_blocked) begin
         for (int i = 0; i < SIZE; i++) tbl[i] <= tbl_n[i];
      end
   end

   assign vld_pipe[0] = i_bp_req;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         vld_pipe[STAGES:1] <= '0;
         o_bp_hit           <= 1'b0;
         o_bp_exec          <= 1'b0;
         o_bp_npc           <= '0;
      end else begin
         vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
         if (i_bp_req) begin
            o_bp_hit  <= rd_hit;
            o_bp_exec <= rd_hit & rd_exec;
            o_bp_npc  <= rd_npc;
         end
      end
   end

   assign o_bp_valid = vld_pipe[STAGES];

endmodule

// File: doc/bp_btb.md
# bp_btb

Branch target buffer for the River branch predictor. Stores up to CFG_BTB_SIZE pairs of {pc, npc}, written by two sources: the pre-decoder, which learns targets from fetched instructions, and the execute stage, which learns them from resolved jumps. It answers one registered lookup per cycle with the predicted next pc. It sits beside the pre-decoder inside the branch predictor and supplies it with learned targets.

## Interface
- CFG_BTB_SIZE, 8: number of entries, 2..16.
- CFG_CPU_ADDR_BITS, 39: pc/npc width.
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_flush_pipeline  in  1  invalidate all entries.
- i_we  in  1  write request.
- i_we_exec  in  1  write source: 1 = execute stage (resolved), 0 = pre-decoder (speculative).
- i_we_pc  in  CFG_CPU_ADDR_BITS  pc of the branch being written.
- i_we_npc  in  CFG_CPU_ADDR_BITS  target of the branch being written.
- i_bp_req  in  1  lookup strobe.
- i_bp_pc  in  CFG_CPU_ADDR_BITS  lookup pc.
- o_bp_valid  out  1  lookup result valid.
- o_bp_hit  out  1  lookup pc found in table.
- o_bp_exec  out  1  hit entry was written by the execute stage.
- o_bp_npc  out  CFG_CPU_ADDR_BITS  predicted next pc.

## Operation
- Entry fields: pc, npc, exec, valid. The table is MRU-ordered: index 0 is most recent.
- Write, when i_we=1 and neither reset nor flush is active:
  - Match search compares i_we_pc against every valid entry. At most one match can exist.
  - Match at k with entry.exec=1 and i_we_exec=0: the write is ignored and the table is unchanged. A speculative write never overrides a resolved one.
  - Match at k otherwise: entries 0..k-1 move to 1..k, and entry 0 becomes {i_we_pc, i_we_npc, i_we_exec, 1}.
  - No match: all entries shift down by one, entry SIZE-1 is discarded, and entry 0 becomes the new entry.
- Lookup, when i_bp_req=1: all valid entries are compared against i_bp_pc.
  - Hit: o_bp_npc = entry.npc, o_bp_hit=1, o_bp_exec = entry.exec.
  - Miss: o_bp_npc = i_bp_pc + 4, truncated to CFG_CPU_ADDR_BITS so it wraps modulo 2^bits. o_bp_hit=0 and o_bp_exec=0.
- Flush: clears valid in all entries. pc, npc and exec keep their values and are don't-care.
- Priority: i_rst > i_flush_pipeline > i_we. A write in a flush cycle is dropped.

## Timing
- Reset values: all entries valid=0, exec=0, pc=npc=0. o_bp_valid=0, o_bp_hit=0, o_bp_exec=0, o_bp_npc=0.
- Lookup latency is 1 cycle. When i_bp_req is sampled high at edge N, o_bp_valid=1 with its result during cycle N+1.
- o_bp_valid=0 in any cycle after a non-request. The other outputs hold their last value.
- Back-to-back requests give one result per cycle, fully pipelined.
- Write latency is 1 cycle. The updated table is visible to a lookup sampled at the next edge.
- Same-edge write and lookup: the lookup sees the pre-write table (read-before-write). There is no bypass.
- Same-edge flush and lookup: the lookup sees the pre-flush table. The result of a lookup issued at the edge after the flush is a miss.
- Reset mid-operation: a lookup sampled together with i_rst produces no result, so o_bp_valid=0 next cycle. Any pending write is lost.
- The table is fully filled after SIZE distinct writes. The next distinct write evicts the LRU entry at index SIZE-1.

## Test plan
- Reset, then lookup pc=0x1000 -> next cycle: valid=1, hit=0, npc=0x1004, exec=0.
- Write (exec=1) pc=0x1000, npc=0x2000, then lookup 0x1000 next cycle -> hit=1, npc=0x2000, exec=1.
- Pre-decoder write pc=0x1000, npc=0x3000 over that exec entry -> lookup still returns npc=0x2000.
- Exec write pc=0x1000, npc=0x3000 -> lookup returns 0x3000.
- Write 9 distinct pcs 0x100, 0x200, …, 0x900 with SIZE=8 -> 0x100 misses (npc=0x104), and 0x200 through 0x900 hit.
- Rewrite 0x200, then write 0xA00 -> 0x300 is evicted and 0x200 is retained.
- Same-edge write pc=0x40/npc=0x80 and lookup 0x40 -> miss (npc=0x44); a lookup one cycle later -> hit with npc=0x80.
- Flush and write on the same edge -> all subsequent lookups miss.
- Lookup at pc=2^39−4 -> miss npc=0x0.
- i_rst asserted with i_bp_req -> o_bp_valid=0 next cycle.
